// File: rtl/sata_oob_device_ctrl.sv
// Device-side SATA OOB responder: answers COMRESET with COMINIT and COMWAKE with COMWAKE,
// then drives ALIGN until the host returns ALIGNs, retrying on timeouts.
module sata_oob_device_ctrl #(
    parameter int unsigned CLKFREQ     = 100_000,
    parameter int unsigned RETRY_US    = 10_000,
    parameter int unsigned ALIGN_TO_US = 55,
    parameter int unsigned RXALIGN_NUM = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       oob_ready,
    output logic       oob_cominit,
    output logic       oob_comwake,
    input  logic       rx_cominit,
    input  logic       rx_comwake,
    input  logic       rxalign,
    output logic       txalign,
    output logic       linkup,
    output logic [2:0] state
);

    localparam longint unsigned T_RETRY = (64'(CLKFREQ) * 64'(RETRY_US)) / 64'd1000;
    localparam longint unsigned T_ALIGN = (64'(CLKFREQ) * 64'(ALIGN_TO_US)) / 64'd1000;
    localparam longint unsigned T_MAX   = (T_RETRY > T_ALIGN) ? T_RETRY : T_ALIGN;
    localparam int TW = (T_MAX < 64'd1) ? 1 : $clog2(T_MAX + 64'd1);
    localparam int CW = (RXALIGN_NUM < 1) ? 1 : $clog2(RXALIGN_NUM + 1);

    // Last timer value still inside the window; the transition fires on it.
    localparam logic [TW-1:0] RETRY_LAST = TW'((T_RETRY > 64'd0) ? T_RETRY - 64'd1 : 64'd0);
    localparam logic [TW-1:0] ALIGN_LAST = TW'((T_ALIGN > 64'd0) ? T_ALIGN - 64'd1 : 64'd0);
    localparam logic [CW-1:0] CNT_LAST   = CW'((RXALIGN_NUM > 0) ? RXALIGN_NUM - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TX_INIT  = 3'd1,
        S_WT_WAKE  = 3'd2,
        S_TX_WAKE  = 3'd3,
        S_TX_ALIGN = 3'd4,
        S_LINKUP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        P_SEND  = 2'd0,
        P_GUARD = 2'd1,
        P_DONE  = 2'd2
    } phase_t;

    state_t          r_state;
    phase_t          r_phase;
    logic            r_guard;
    logic [TW-1:0]   r_timer;
    logic [CW-1:0]   r_cnt;
    logic            r_txalign;
    logic            r_linkup;
    logic            w_cmd_fire;

    // The command strobe is qualified by the live oob_ready so it can never be
    // presented to the coder while it is busy; the phase register makes it one cycle.
    assign w_cmd_fire  = !reset && !rx_cominit && oob_ready && (r_phase == P_SEND) &&
                         ((r_state == S_TX_INIT) || (r_state == S_TX_WAKE));
    assign oob_cominit = w_cmd_fire && (r_state == S_TX_INIT);
    assign oob_comwake = w_cmd_fire && (r_state == S_TX_WAKE);
    assign txalign     = r_txalign;
    assign linkup      = r_linkup;
    assign state       = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_phase   <= P_SEND;
            r_guard   <= 1'b0;
            r_timer   <= '0;
            r_cnt     <= '0;
            r_txalign <= 1'b0;
            r_linkup  <= 1'b0;
        end else if (rx_cominit) begin
            r_state   <= S_TX_INIT;
            r_phase   <= P_SEND;
            r_guard   <= 1'b0;
            r_timer   <= '0;
            r_cnt     <= '0;
            r_txalign <= 1'b0;
            r_linkup  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_phase <= P_SEND;
                end
                S_TX_INIT, S_TX_WAKE: begin
                    case (r_phase)
                        P_SEND: begin
                            if (oob_ready) begin
                                r_phase <= P_GUARD;
                                r_guard <= 1'b0;
                            end
                        end
                        P_GUARD: begin
                            if (r_guard) r_phase <= P_DONE;
                            else         r_guard <= 1'b1;
                        end
                        P_DONE: begin
                            if (oob_ready) begin
                                r_phase <= P_SEND;
                                r_timer <= '0;
                                r_cnt   <= '0;
                                if (r_state == S_TX_INIT) begin
                                    r_state <= S_WT_WAKE;
                                end else begin
                                    r_state   <= S_TX_ALIGN;
                                    r_txalign <= 1'b1;
                                end
                            end
                        end
                        default: r_phase <= P_SEND;
                    endcase
                end
                S_WT_WAKE: begin
                    if (rx_comwake) begin
                        r_state <= S_TX_WAKE;
                        r_phase <= P_SEND;
                    end else if (r_timer >= RETRY_LAST) begin
                        r_state <= S_TX_INIT;
                        r_phase <= P_SEND;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_TX_ALIGN: begin
                    // Link-up is tested before the timeout so it wins a tie.
                    if (rxalign && (r_cnt >= CNT_LAST)) begin
                        r_state  <= S_LINKUP;
                        r_linkup <= 1'b1;
                    end else if (r_timer >= ALIGN_LAST) begin
                        r_state   <= S_TX_INIT;
                        r_phase   <= P_SEND;
                        r_txalign <= 1'b0;
                        r_timer   <= '0;
                        r_cnt     <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        r_cnt   <= rxalign ? r_cnt + 1'b1 : '0;
                    end
                end
                S_LINKUP: begin
                    r_linkup  <= 1'b1;
                    r_txalign <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sata_oob_device_ctrl.sv
// Randomized scoreboard bench for sata_oob_device_ctrl: the driver predicts command pulses
// and linkup edges with their cycle numbers, a negedge monitor pops and compares them.
module tb_sata_oob_device_ctrl;

    localparam int EV_CI = 0;
    localparam int EV_CW = 1;
    localparam int EV_LR = 2;
    localparam int EV_LF = 3;
    localparam int T_RETRY = 50;
    localparam int T_ALIGN = 20;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       oob_ready = 1'b0;
    logic       rx_cominit = 1'b0;
    logic       rx_comwake = 1'b0;
    logic       rxalign = 1'b0;
    logic       oob_cominit;
    logic       oob_comwake;
    logic       txalign;
    logic       linkup;
    logic [2:0] state;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    bit  prev_link = 1'b0;
    ev_t exp_q[$];

    sata_oob_device_ctrl #(
        .CLKFREQ(1000), .RETRY_US(50), .ALIGN_TO_US(20), .RXALIGN_NUM(2)
    ) dut (
        .clk(clk), .reset(reset), .oob_ready(oob_ready),
        .oob_cominit(oob_cominit), .oob_comwake(oob_comwake),
        .rx_cominit(rx_cominit), .rx_comwake(rx_comwake), .rxalign(rxalign),
        .txalign(txalign), .linkup(linkup), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic see(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event cyc=%0d actual=%0d required=none", cyc, kind);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (oob_cominit || oob_comwake) begin
                check("cmd_exclusive", int'(oob_cominit && oob_comwake), 0);
                check("cmd_needs_ready", int'(oob_ready), 1);
            end
            if (prev_link && !linkup) see(EV_LF);
            if (!prev_link && linkup) see(EV_LR);
            if (oob_cominit) see(EV_CI);
            if (oob_comwake) see(EV_CW);
            prev_link = linkup;
            $display("cyc=%0d state=%0d ready=%0b ci=%0b cw=%0b txa=%0b lnk=%0b",
                     cyc, state, oob_ready, oob_cominit, oob_comwake, txalign, linkup);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_side();
        rxalign   = 1'($urandom_range(0, 1));
        oob_ready = 1'($urandom_range(0, 1));
    endtask

    // Coder model: ready low d0 cycles, accepts at p, busy b cycles, then ready again.
    task automatic handshake(input int kind, input int d0, input int b, input int st_next);
        int s = cyc;
        int p = s + d0;
        int n = (p + 3 > p + b + 1) ? p + 3 : p + b + 1;
        push(kind, p);
        for (int t = s; t <= n; t++) begin
            rx_cominit = 1'b0;
            rx_comwake = 1'b0;
            rxalign    = 1'($urandom_range(0, 1));
            if (t < p)           oob_ready = 1'b0;
            else if (t == p)     oob_ready = 1'b1;
            else if (t <= p + b) oob_ready = 1'b0;
            else                 oob_ready = 1'b1;
            tick();
        end
        check("hs_state", int'(state), st_next);
        check("hs_txalign", int'(txalign), (st_next == 4) ? 1 : 0);
    endtask

    task automatic pulse_cominit(input bit with_wake, input bit from_link);
        if (from_link) push(EV_LF, cyc + 1);
        rx_cominit = 1'b1;
        rx_comwake = with_wake;
        rand_side();
        tick();
        rx_cominit = 1'b0;
        rx_comwake = 1'b0;
        check("rst_state", int'(state), 1);
        check("rst_txalign", int'(txalign), 0);
        check("rst_linkup", int'(linkup), 0);
    endtask

    task automatic wake_wait(input int w);
        for (int t = 0; t < w; t++) begin
            rx_comwake = 1'b0;
            rand_side();
            tick();
        end
        rx_comwake = 1'b1;
        rand_side();
        tick();
        rx_comwake = 1'b0;
        check("wake_state", int'(state), 3);
    endtask

    task automatic wake_timeout();
        for (int t = 0; t < T_RETRY; t++) begin
            if (t == T_RETRY - 1) check("retry_edge_state", int'(state), 2);
            rx_comwake = 1'b0;
            rand_side();
            tick();
        end
        check("retry_state", int'(state), 1);
    endtask

    // mode 0: ALIGN pair after k cycles of isolated ALIGNs; 1: strict 1,0,..; 2: random isolated.
    task automatic align_phase(input int mode, input int kforce);
        int a = cyc;
        int k;
        bit prev = 1'b0;
        bit v;
        if (mode == 0) begin
            k = (kforce >= 0) ? kforce : $urandom_range(0, 18);
            push(EV_LR, a + k + 2);
            for (int t = 0; t < k; t++) begin
                v = (t == k - 1 || prev) ? 1'b0 : 1'($urandom_range(0, 1));
                rxalign = v;
                prev = v;
                oob_ready = 1'($urandom_range(0, 1));
                tick();
            end
            for (int t = 0; t < 2; t++) begin
                rxalign = 1'b1;
                tick();
            end
            rxalign = 1'b0;
            check("link_state", int'(state), 5);
            check("link_linkup", int'(linkup), 1);
            check("link_txalign", int'(txalign), 1);
        end else begin
            for (int t = 0; t < T_ALIGN; t++) begin
                if (t == T_ALIGN - 1) check("align_edge_txalign", int'(txalign), 1);
                v = (mode == 1) ? (t % 2 == 0) : (prev ? 1'b0 : 1'($urandom_range(0, 1)));
                rxalign = v;
                prev = v;
                oob_ready = 1'($urandom_range(0, 1));
                tick();
            end
            rxalign = 1'b0;
            check("align_to_state", int'(state), 1);
            check("align_to_txalign", int'(txalign), 0);
            check("align_to_linkup", int'(linkup), 0);
        end
    endtask

    task automatic hold_link(input int h);
        for (int t = 0; t < h; t++) begin
            rx_comwake = 1'($urandom_range(0, 1));
            rand_side();
            tick();
        end
        rx_comwake = 1'b0;
        check("hold_state", int'(state), 5);
    endtask

    initial begin
        // Reset held with random inputs, then one idle cycle.
        for (int i = 0; i < 3; i++) begin
            tick();
            rx_cominit = 1'($urandom_range(0, 1));
            rx_comwake = 1'($urandom_range(0, 1));
            rand_side();
            #3;
            check("reset_state", int'(state), 0);
            check("reset_cmds", int'({oob_cominit, oob_comwake}), 0);
            check("reset_link", int'({txalign, linkup}), 0);
        end
        tick();
        reset = 1'b0;
        rx_cominit = 1'b0;
        rx_comwake = 1'b0;
        rxalign = 1'b0;
        oob_ready = 1'b0;
        #3;
        check("post_reset_state", int'(state), 0);
        check("post_reset_outs", int'({oob_cominit, oob_comwake, txalign, linkup}), 0);
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            rx_comwake = 1'($urandom_range(0, 1));
            rand_side();
        end
        tick();
        rx_comwake = 1'b0;
        check("idle_ignores_wake", int'(state), 0);

        // Full bring-up with a coder that is busy for 10 cycles after each command.
        pulse_cominit(1'b0, 1'b0);
        handshake(EV_CI, $urandom_range(0, 3), 10, 2);
        wake_wait($urandom_range(0, 40));
        handshake(EV_CW, $urandom_range(0, 3), 10, 4);
        align_phase(0, -1);

        // Host COMRESET from LINKUP, then two COMWAKE retries.
        hold_link($urandom_range(1, 8));
        pulse_cominit(1'b0, 1'b1);
        handshake(EV_CI, $urandom_range(0, 5), $urandom_range(0, 12), 2);
        for (int r = 0; r < 2; r++) begin
            wake_timeout();
            handshake(EV_CI, 0, $urandom_range(0, 12), 2);
        end

        // ALIGN timeouts: alternating pattern, then random isolated ALIGNs.
        wake_wait($urandom_range(0, 40));
        handshake(EV_CW, $urandom_range(0, 5), $urandom_range(0, 12), 4);
        align_phase(1, -1);
        handshake(EV_CI, $urandom_range(0, 5), $urandom_range(0, 12), 2);
        wake_wait($urandom_range(0, 40));
        handshake(EV_CW, $urandom_range(0, 5), $urandom_range(0, 12), 4);
        align_phase(2, -1);

        // Simultaneous COMRESET/COMWAKE in WT_WAKE; coder stalled 100 cycles.
        handshake(EV_CI, $urandom_range(0, 5), $urandom_range(0, 12), 2);
        wake_wait(T_RETRY - 1 - 10);
        handshake(EV_CW, 0, 0, 4);
        align_phase(0, 18);
        pulse_cominit(1'b0, 1'b1);
        handshake(EV_CI, 0, 0, 2);
        pulse_cominit(1'b1, 1'b0);
        handshake(EV_CI, 100, $urandom_range(0, 12), 2);

        // Random full cycles.
        for (int r = 0; r < 3; r++) begin
            wake_wait($urandom_range(0, 45));
            handshake(EV_CW, $urandom_range(0, 6), $urandom_range(0, 12), 4);
            align_phase(0, -1);
            hold_link($urandom_range(1, 10));
            pulse_cominit(1'($urandom_range(0, 1)), 1'b1);
            handshake(EV_CI, $urandom_range(0, 6), $urandom_range(0, 12), 2);
        end

        for (int i = 0; i < 4; i++) begin
            rand_side();
            tick();
        end
        check("events_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
